game_motion_controller: RTL

GAME_MOTION_CONTROLLER -- requirements
Module: game_motion_controller

---
 rtl/game_pkg.sv | 39 +++
 rtl/edge_pulse.sv | 56 +++++
 rtl/game_motion_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// ============================================================================
//  Module      : game_pkg
//  Description : Shared state encoding, default geometry/physics constants and
//                helper functions for the game motion controller and the VGA
//                stage (sprite width lives here too).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

   // Coordinate and velocity widths
   localparam int POS_W = 12;
   localparam int VEL_W = 8;
   localparam int SCORE_W = 16;

   // Default geometry / physics
   localparam int GROUND_Y_DEF     = 320;
   localparam int DINO_X_DEF       = 240;
   localparam int OBST_START_X_DEF = 680;
   localparam int OBST_SPEED_DEF   = 4;
   localparam int JUMP_V0_DEF      = 18;
   localparam int GRAVITY_DEF      = 1;
   localparam int SPRITE_W         = 50;

   // Game state encoding
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_JUMP = 2'd2;
   localparam logic [1:0] S_OVER = 2'd3;

   // Score counter that sticks at its maximum instead of rolling over
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == {SCORE_W{1'b1}}) ? v : v + {{(SCORE_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

`default_nettype wire

// File: rtl/edge_pulse.sv
// ============================================================================
//  Module      : edge_pulse
//  Description : Registers an input level and produces a one-cycle pulse on
//                its rising edge. With SYNC=1 the input first passes a 2-flop
//                synchronizer (for asynchronous sources).
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                i_d    - input level
//                o_rise - one-cycle pulse on rising edge of (synchronized) i_d
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_pulse #(
   parameter bit SYNC = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_rise
);

   logic w_level;
   logic r_prev;

   generate
      if (SYNC) begin : g_sync
         logic r_s1;
         logic r_s2;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s1 <= 1'b0;
               r_s2 <= 1'b0;
            end else begin
               r_s1 <= i_d;
               r_s2 <= r_s1;
            end
         end
         assign w_level = r_s2;
      end else begin : g_nosync
         // Source is already synchronous; the pulse is combinational on i_d
         // so the consumer acts on the very edge where i_d is first high.
         assign w_level = i_d;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_prev <= 1'b0;
      else        r_prev <= w_level;
   end

   assign o_rise = w_level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/game_motion_controller.sv
// ============================================================================
//  Module      : game_motion_controller
//  Description : Frame-stepped dino/obstacle motion, jump physics, scoring and
//                game state (IDLE/RUN/JUMP/OVER).
//  Ports       : clk                - system clock
//                reset              - asynchronous active-low reset
//                jump_btn           - raw asynchronous jump button
//                screen_ready       - end-of-frame strobe from the VGA stage
//                collision_detected - overlap flag from the VGA stage
//                x_coor / y_coor    - dino left column / bottom row
//                x_coor_obstacle    - obstacle left column
//                y_coor_obstacle    - obstacle bottom row (ground)
//                score              - obstacles cleared (saturating)
//                game_over          - high in OVER state
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_motion_controller
   import game_pkg::*;
#(
   parameter int GROUND_Y     = GROUND_Y_DEF,
   parameter int DINO_X       = DINO_X_DEF,
   parameter int OBST_START_X = OBST_START_X_DEF,
   parameter int OBST_SPEED   = OBST_SPEED_DEF,
   parameter int JUMP_V0      = JUMP_V0_DEF,
   parameter int GRAVITY      = GRAVITY_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        jump_btn,
   input  logic        screen_ready,
   input  logic        collision_detected,
   output logic [31:0] x_coor,
   output logic [31:0] y_coor,
   output logic [31:0] x_coor_obstacle,
   output logic [31:0] y_coor_obstacle,
   output logic [15:0] score,
   output logic        game_over
);

   localparam logic [POS_W-1:0]        c_ground_y = POS_W'(GROUND_Y);
   localparam logic [POS_W-1:0]        c_dino_x   = POS_W'(DINO_X);
   localparam logic [POS_W-1:0]        c_obst_x0  = POS_W'(OBST_START_X);
   localparam logic [POS_W-1:0]        c_speed    = POS_W'(OBST_SPEED);
   localparam logic signed [VEL_W-1:0] c_v0       = VEL_W'(JUMP_V0);
   localparam logic signed [VEL_W-1:0] c_grav     = VEL_W'(GRAVITY);

   logic                      w_jump_press;
   logic                      w_frame_tick;

   logic [1:0]                r_state;
   logic [POS_W-1:0]          r_y;
   logic signed [VEL_W-1:0]   r_vel;
   logic [POS_W-1:0]          r_xo;
   logic [SCORE_W-1:0]        r_score;
   logic                      r_jump_pend;

   logic                      w_jump_req;
   logic signed [VEL_W-1:0]   w_vel_cur;
   logic signed [VEL_W-1:0]   w_vel_next;
   logic [POS_W-1:0]          w_y_next;
   logic                      w_land;
   logic                      w_xo_wrap;

   edge_pulse #(.SYNC(1'b1)) u_jump_edge (
      .clk    (clk),
      .rst_n  (reset),
      .i_d    (jump_btn),
      .o_rise (w_jump_press)
   );

   edge_pulse #(.SYNC(1'b0)) u_frame_edge (
      .clk    (clk),
      .rst_n  (reset),
      .i_d    (screen_ready),
      .o_rise (w_frame_tick)
   );

   // A press in RUN may arrive on the tick itself or earlier in the frame
   assign w_jump_req = r_jump_pend | w_jump_press;

   // The tick that launches a jump already applies the first step at JUMP_V0
   assign w_vel_cur  = (r_state == S_RUN) ? c_v0 : r_vel;
   assign w_y_next   = r_y - {{(POS_W-VEL_W){w_vel_cur[VEL_W-1]}}, w_vel_cur};
   assign w_vel_next = w_vel_cur - c_grav;
   assign w_land     = (w_vel_next <= 0) && (w_y_next >= c_ground_y);
   assign w_xo_wrap  = (r_xo < c_speed);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_y         <= c_ground_y;
         r_vel       <= '0;
         r_xo        <= c_obst_x0;
         r_score     <= '0;
         r_jump_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_jump_press) r_state <= S_RUN;
            end

            S_RUN, S_JUMP: begin
               if (w_frame_tick) begin
                  r_jump_pend <= 1'b0;
                  if (collision_detected) begin
                     r_state <= S_OVER;
                  end else begin
                     if (w_xo_wrap) begin
                        r_xo    <= c_obst_x0;
                        r_score <= sat_inc(r_score);
                     end else begin
                        r_xo <= r_xo - c_speed;
                     end

                     if (r_state == S_JUMP || w_jump_req) begin
                        if (w_land) begin
                           r_y     <= c_ground_y;
                           r_vel   <= '0;
                           r_state <= S_RUN;
                        end else begin
                           r_y     <= w_y_next;
                           r_vel   <= w_vel_next;
                           r_state <= S_JUMP;
                        end
                     end
                  end
               end else if (r_state == S_RUN && w_jump_press) begin
                  r_jump_pend <= 1'b1;
               end
            end

            default: begin // S_OVER
               if (w_jump_press) begin
                  r_state     <= S_IDLE;
                  r_y         <= c_ground_y;
                  r_vel       <= '0;
                  r_xo        <= c_obst_x0;
                  r_score     <= '0;
                  r_jump_pend <= 1'b0;
               end
            end
         endcase
      end
   end

   assign x_coor          = 32'(c_dino_x);
   assign y_coor          = 32'(r_y);
   assign x_coor_obstacle = 32'(r_xo);
   assign y_coor_obstacle = 32'(c_ground_y);
   assign score           = r_score;
   assign game_over       = (r_state == S_OVER);

endmodule

`default_nettype wire
